// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the forwarding/hazard logic.
//   REG_W        : register-index width (8 GPRs)
//   fwd_sel_t    : ALU operand-mux bypass select encoding
//   pipe_slot_t  : tracked producer state for one pipeline stage
package pipeline_pkg;

  localparam int unsigned REG_W = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [SEL_W-1:0] {
    FWD_RF         = 2'd0,
    FWD_EXMEM      = 2'd1,
    FWD_MEMWB_ALU  = 2'd2,
    FWD_MEMWB_LOAD = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             wb;
    logic             mem_read;
  } pipe_slot_t;

  localparam pipe_slot_t SLOT_EMPTY = '{valid: 1'b0, dst: '0, wb: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/hazard_operand_cmp.sv
// Per-operand producer compare (purely combinational).
//   ex_slot, mem_slot : producers currently in EX and MEM
//   operand, use_op   : register index read by the decoding instruction
//   sel_c             : bypass select for this operand
//   load_hit_c        : operand depends on a load still in EX (needs a stall)
module hazard_operand_cmp
  import pipeline_pkg::*;
(
  input  pipe_slot_t       ex_slot,
  input  pipe_slot_t       mem_slot,
  input  logic [REG_W-1:0] operand,
  input  logic             use_op,
  output fwd_sel_t         sel_c,
  output logic             load_hit_c
);

  logic ex_hit;
  logic mem_hit;

  // EX is the younger producer, so it takes priority over MEM.
  always_comb begin
    ex_hit     = ex_slot.valid && ex_slot.wb && (ex_slot.dst == operand) && use_op;
    mem_hit    = mem_slot.valid && mem_slot.wb && (mem_slot.dst == operand) && use_op;
    sel_c      = FWD_RF;
    load_hit_c = ex_hit && ex_slot.mem_read;
    if (ex_hit && !ex_slot.mem_read) begin
      sel_c = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_c = mem_slot.mem_read ? FWD_MEMWB_LOAD : FWD_MEMWB_ALU;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// ALU operand-forwarding and load-use hazard unit.
// Tracks the EX and MEM producers, registers per-operand bypass selects for the
// instruction entering EX, and raises a combinational load-use stall.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid .. id_mem_read    : decoding instruction description
//   flush                      : squash the instruction entering EX
//   stall                      : combinational load-use stall / bubble request
//   fwd_src_sel, fwd_dst_sel   : registered ALU operand selects (valid in EX)
// Optional (HAZARD_STATS_EN defined):
//   stall_count, fwd_count     : saturating event counters
module forwarding_hazard_unit
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_use_src,
  input  logic             id_use_dst,
  input  logic             id_wb,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_src_sel,
  output logic [SEL_W-1:0] fwd_dst_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
`endif
);

  pipe_slot_t ex_slot;
  pipe_slot_t mem_slot;
  fwd_sel_t   src_sel_q;
  fwd_sel_t   dst_sel_q;
  fwd_sel_t   src_sel_c;
  fwd_sel_t   dst_sel_c;
  logic       src_load_hit_c;
  logic       dst_load_hit_c;
  logic       accept_c;

  hazard_operand_cmp u_src_cmp (
    .ex_slot    (ex_slot),
    .mem_slot   (mem_slot),
    .operand    (id_src),
    .use_op     (id_use_src),
    .sel_c      (src_sel_c),
    .load_hit_c (src_load_hit_c)
  );

  hazard_operand_cmp u_dst_cmp (
    .ex_slot    (ex_slot),
    .mem_slot   (mem_slot),
    .operand    (id_dst),
    .use_op     (id_use_dst),
    .sel_c      (dst_sel_c),
    .load_hit_c (dst_load_hit_c)
  );

  // Load-use stall, and whether the decoding instruction actually enters EX.
  always_comb begin
    stall    = id_valid && (src_load_hit_c || dst_load_hit_c);
    accept_c = id_valid && !stall && !flush;
  end

  // Slot advance and select registers; a rejected instruction becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot   <= SLOT_EMPTY;
      mem_slot  <= SLOT_EMPTY;
      src_sel_q <= FWD_RF;
      dst_sel_q <= FWD_RF;
    end else begin
      mem_slot <= ex_slot;
      if (accept_c) begin
        ex_slot   <= '{valid: 1'b1, dst: id_dst, wb: id_wb, mem_read: id_mem_read};
        src_sel_q <= src_sel_c;
        dst_sel_q <= dst_sel_c;
      end else begin
        ex_slot   <= SLOT_EMPTY;
        src_sel_q <= FWD_RF;
        dst_sel_q <= FWD_RF;
      end
    end
  end

  assign fwd_src_sel = src_sel_q;
  assign fwd_dst_sel = dst_sel_q;

`ifdef HAZARD_STATS_EN
  // Saturating counters: stall cycles, and cycles latching any nonzero select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (accept_c && ((src_sel_c != FWD_RF) || (dst_sel_c != FWD_RF)) && (fwd_count != '1)) begin
        fwd_count <= fwd_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed testbench for forwarding_hazard_unit (optionally with HAZARD_STATS_EN).
module tb_forwarding_hazard_unit;
  import pipeline_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_src;
  logic [REG_W-1:0] id_dst;
  logic             id_use_src;
  logic             id_use_dst;
  logic             id_wb;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] fwd_src_sel;
  logic [SEL_W-1:0] fwd_dst_sel;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] fwd_count;
`endif

  int n_checks;
  int n_fail;

  forwarding_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_dst      (id_dst),
    .id_use_src  (id_use_src),
    .id_use_dst  (id_use_dst),
    .id_wb       (id_wb),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .stall       (stall),
    .fwd_src_sel (fwd_src_sel),
    .fwd_dst_sel (fwd_dst_sel)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count),
    .fwd_count   (fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int src, input int dst, input logic us,
                       input logic ud, input logic wb, input logic mr, input logic fl);
    id_valid    = v;
    id_src      = REG_W'(src);
    id_dst      = REG_W'(dst);
    id_use_src  = us;
    id_use_dst  = ud;
    id_wb       = wb;
    id_mem_read = mr;
    flush       = fl;
  endtask

  // Present one decode cycle: check stall before the edge, selects after it.
  task automatic step(input string tag, input logic v, input int src, input int dst,
                      input logic us, input logic ud, input logic wb, input logic mr,
                      input logic fl, input int exp_stall, input int exp_src, input int exp_dst);
    drive(v, src, dst, us, ud, wb, mr, fl);
    #1;
    check({tag, "_stall"}, 32'(stall), exp_stall);
    @(posedge clk);
    #1;
    check({tag, "_src"}, 32'(fwd_src_sel), exp_src);
    check({tag, "_dst"}, 32'(fwd_dst_sel), exp_dst);
  endtask

  task automatic nop(input string tag);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_stall", 32'(stall), 0);
    check("rst_src", 32'(fwd_src_sel), 0);
    check("rst_dst", 32'(fwd_dst_sel), 0);
    rst_n = 1'b1;

    // EX/MEM forward: ADD R1,R2 ; SUB R3,R1
    step("t1_add", 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step("t1_sub", 1, 1, 3, 1, 1, 1, 0, 0, 0, 1, 0);
    nop("n"); nop("n");

    // MEM/WB ALU forward: ADD R1 ; NOP ; OR R4,R1
    step("t2_add", 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step("t2_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t2_or",  1, 1, 4, 1, 1, 1, 0, 0, 0, 2, 0);
    nop("n"); nop("n");

    // Load-use: LDD R5 ; ADD R5,R6 -> one stall, then load-data forward
    step("t3_ldd",   1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0);
    step("t3_stall", 1, 5, 6, 1, 1, 1, 0, 0, 1, 0, 0);
    step("t3_fwd",   1, 5, 6, 1, 1, 1, 0, 0, 0, 3, 0);
    step("t3_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("n");

    // Both slots write R2: younger (EX) wins
    step("t4_add", 1, 3, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    step("t4_inc", 1, 0, 2, 0, 1, 1, 0, 0, 0, 0, 1);
    step("t4_and", 1, 7, 2, 1, 1, 1, 0, 0, 0, 0, 1);
    nop("n"); nop("n");

    // Non-writing producer: STD R1 ; ADD R1
    step("t5_std", 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("t5_add", 1, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    nop("n"); nop("n");

    // Flush: ADD R3 ; SUB R4,R3 (flushed) ; OR R5,R3 sees ADD only via MEM
    step("t6_add",   1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    step("t6_flush", 1, 3, 4, 1, 1, 1, 0, 1, 0, 0, 0);
    step("t6_or",    1, 3, 5, 1, 1, 1, 0, 0, 0, 2, 0);
    nop("n"); nop("n");

    // Stall and flush together: bubble, then load forward without restall
    step("t7_ldd", 1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0);
    step("t7_sf",  1, 5, 6, 1, 1, 1, 0, 1, 1, 0, 0);
    step("t7_fwd", 1, 5, 6, 1, 1, 1, 0, 0, 0, 3, 0);
    nop("n"); nop("n");

    // Asynchronous reset in the middle of a stall
    step("t8_add", 1, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0);
    step("t8_ldd", 1, 7, 5, 1, 0, 1, 1, 0, 0, 1, 0);
    drive(1'b1, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("t8_pre_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_stall", 32'(stall), 0);
    check("t8_rst_src", 32'(fwd_src_sel), 0);
    check("t8_rst_dst", 32'(fwd_dst_sel), 0);
`ifdef HAZARD_STATS_EN
    check("t8_rst_scnt", 32'(stall_count), 0);
`endif
    #1;
    rst_n = 1'b1;
    #1;
    check("t8_redecode_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    check("t8_redecode_src", 32'(fwd_src_sel), 0);
    nop("n"); nop("n");

    // Three load-use stalls back to back
    for (int i = 0; i < 3; i++) begin
      step("t9_ldd",   1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0);
      step("t9_stall", 1, 5, 6, 1, 1, 1, 0, 0, 1, 0, 0);
      step("t9_fwd",   1, 5, 6, 1, 1, 1, 0, 0, 0, 3, 0);
    end
`ifdef HAZARD_STATS_EN
    check("t9_stall_count", 32'(stall_count), 3);
    check("t9_fwd_count", 32'(fwd_count), 3);
`endif
    rst_n = 1'b0;
    #1;
    check("t9_rst_src", 32'(fwd_src_sel), 0);
`ifdef HAZARD_STATS_EN
    check("t9_rst_scnt", 32'(stall_count), 0);
    check("t9_rst_fcnt", 32'(fwd_count), 0);
`endif
    #2;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
